// File: rtl/seq_alu_pkg.sv
// Shared definitions for the registered sequential ALU: opcode values,
// flag bit positions inside the {V,C,N,Z} flag vector and FSM state encoding.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_INC = 4'b0110;
    localparam logic [3:0] OP_DEC = 4'b0111;
    localparam logic [3:0] OP_ADC = 4'b1000;
    localparam logic [3:0] OP_SBB = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier. A start pulse loads the operands;
// one partial-product step runs per cycle for WIDTH cycles. done is high
// during the final step, and product then carries the value that step
// produces, so the caller can capture it at the same edge.
module seq_alu_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic               run;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;

    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
    assign done    = run && (cnt == CNT_W'(WIDTH - 1));
    assign product = acc_nxt;

    // Step counter and run flag; reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CNT_W'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

    // Operand shift registers and partial-product accumulator.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (run) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake, stored {V,C,N,Z} flags for
// carry-chained ADC/SBB, shifts and an optional multi-cycle multiply.
// Define SEQ_ALU_MUL_EN to build opcode 1100 as the shift-add multiply;
// without it 1100 completes as an illegal opcode and busy stays 0.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic [3:0]       flags,
    output logic             err,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z,
                                               input logic ci);
        return {1'b0, x} + {1'b0, z} + {{WIDTH{1'b0}}, ci};
    endfunction

    function automatic logic [WIDTH:0] sub_ext(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z,
                                               input logic bi);
        return {1'b0, x} - {1'b0, z} - {{WIDTH{1'b0}}, bi};
    endfunction

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] z,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == z[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow: operands differ in sign and the result sign flips from x.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] z,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != z[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    logic             accept;
    logic             mul_start;
    logic             mul_finish;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             sc_illegal;
    logic [3:0]       sc_flags;

    assign accept = in_valid && in_ready;

    // Single-cycle datapath: result, carry/borrow and overflow for each opcode.
    always_comb begin
        ext        = '0;
        sc_res     = '0;
        sc_c       = 1'b0;
        sc_v       = 1'b0;
        sc_illegal = 1'b0;
        case (op)
            OP_ADD: begin
                ext    = add_ext(a, b, cin);
                sc_res = ext[WIDTH-1:0];
                sc_c   = ext[WIDTH];
                sc_v   = add_ovf(a, b, ext[WIDTH-1:0]);
            end
            OP_SUB: begin
                ext    = sub_ext(a, b, cin);
                sc_res = ext[WIDTH-1:0];
                sc_c   = ext[WIDTH];
                sc_v   = sub_ovf(a, b, ext[WIDTH-1:0]);
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_NOT: sc_res = ~a;
            OP_INC: begin
                ext    = add_ext(a, ONE, 1'b0);
                sc_res = ext[WIDTH-1:0];
                sc_c   = ext[WIDTH];
                sc_v   = add_ovf(a, ONE, ext[WIDTH-1:0]);
            end
            OP_DEC: begin
                ext    = sub_ext(a, ONE, 1'b0);
                sc_res = ext[WIDTH-1:0];
                sc_c   = ext[WIDTH];
                sc_v   = sub_ovf(a, ONE, ext[WIDTH-1:0]);
            end
            OP_ADC: begin
                ext    = add_ext(a, b, flags[FLG_C]);
                sc_res = ext[WIDTH-1:0];
                sc_c   = ext[WIDTH];
                sc_v   = add_ovf(a, b, ext[WIDTH-1:0]);
            end
            OP_SBB: begin
                ext    = sub_ext(a, b, flags[FLG_C]);
                sc_res = ext[WIDTH-1:0];
                sc_c   = ext[WIDTH];
                sc_v   = sub_ovf(a, b, ext[WIDTH-1:0]);
            end
            OP_SHL: begin
                sc_res = {a[WIDTH-2:0], 1'b0};
                sc_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                sc_res = {1'b0, a[WIDTH-1:1]};
                sc_c   = a[0];
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: sc_res = '0;
`endif
            default: sc_illegal = 1'b1;
        endcase
    end

    // Pack the {V,C,N,Z} vector for a single-cycle result.
    always_comb begin
        sc_flags        = '0;
        sc_flags[FLG_Z] = (sc_res == '0);
        sc_flags[FLG_N] = sc_res[WIDTH-1];
        sc_flags[FLG_C] = sc_c;
        sc_flags[FLG_V] = sc_v;
    end

`ifdef SEQ_ALU_MUL_EN
    state_t             state;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    logic [3:0]         mul_flags;

    assign in_ready   = (state == ST_IDLE) && (!out_valid || out_ready);
    assign mul_start  = accept && (op == OP_MUL);
    assign mul_finish = (state == ST_MUL) && mul_done;

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    // Flags for the finished product: overflow/carry mean the high half is used.
    always_comb begin
        mul_flags        = '0;
        mul_flags[FLG_Z] = (product == '0);
        mul_flags[FLG_N] = product[2*WIDTH-1];
        mul_flags[FLG_C] = (product[2*WIDTH-1:WIDTH] != '0);
        mul_flags[FLG_V] = (product[2*WIDTH-1:WIDTH] != '0);
    end
`else
    assign in_ready   = !out_valid || out_ready;
    assign mul_start  = 1'b0;
    assign mul_finish = 1'b0;
    assign busy       = 1'b0;
`endif

    // Output register, handshake and multiply FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            y_hi      <= '0;
            flags     <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            state     <= ST_IDLE;
            busy      <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !mul_start) begin
                out_valid <= 1'b1;
                y_hi      <= '0;
                if (sc_illegal) begin
                    y   <= '0;
                    err <= 1'b1;
                end else begin
                    y     <= sc_res;
                    flags <= sc_flags;
                    err   <= 1'b0;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            if (mul_start) begin
                state <= ST_MUL;
                busy  <= 1'b1;
            end
            if (mul_finish) begin
                y         <= product[WIDTH-1:0];
                y_hi      <= product[2*WIDTH-1:WIDTH];
                flags     <= mul_flags;
                err       <= 1'b0;
                out_valid <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=4 with hand-computed results.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic [3:0] y_hi;
    logic [3:0] flags;
    logic       err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    seq_alu #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .flags     (flags),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [3:0] xa,
                         input logic [3:0] xb, input logic ci);
        int guard;
        guard    = 0;
        op       = o;
        a        = xa;
        b        = xb;
        cin      = ci;
        in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [3:0] ey, input logic [3:0] eyh,
                              input logic [3:0] ef, input logic ee);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_y"},     32'(y),         32'(ey));
        chk({tag, "_y_hi"},  32'(y_hi),      32'(eyh));
        chk({tag, "_flags"}, 32'(flags),     32'(ef));
        chk({tag, "_err"},   32'(err),       32'(ee));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 4'b0000;
        a         = 4'b0000;
        b         = 4'b0000;
        cin       = 1'b0;
        tick();
        tick();
        chk("rst_y",     32'(y),         32'd0);
        chk("rst_y_hi",  32'(y_hi),      32'd0);
        chk("rst_flags", 32'(flags),     32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd1);

        // Arithmetic chain with stored carry; flags are {V,C,N,Z}.
        issue(4'b0000, 4'hF, 4'h1, 1'b1); expect_res("add",   4'h1, 4'h0, 4'b0100, 1'b0);
        issue(4'b1000, 4'h2, 4'h3, 1'b0); expect_res("adc",   4'h6, 4'h0, 4'b0000, 1'b0);
        issue(4'b0000, 4'hF, 4'h1, 1'b0); expect_res("add_c", 4'h0, 4'h0, 4'b0101, 1'b0);
        issue(4'b1001, 4'h0, 4'h0, 1'b0); expect_res("sbb",   4'hF, 4'h0, 4'b0110, 1'b0);
        issue(4'b0001, 4'h7, 4'h8, 1'b0); expect_res("sub",   4'hF, 4'h0, 4'b1110, 1'b0);
        issue(4'b0111, 4'h0, 4'h5, 1'b0); expect_res("dec",   4'hF, 4'h0, 4'b0110, 1'b0);

        // Logic, increment and shift operations.
        issue(4'b0010, 4'hC, 4'hA, 1'b0); expect_res("and",   4'h8, 4'h0, 4'b0010, 1'b0);
        issue(4'b0011, 4'hC, 4'hA, 1'b0); expect_res("or",    4'hE, 4'h0, 4'b0010, 1'b0);
        issue(4'b0100, 4'hC, 4'hA, 1'b0); expect_res("xor",   4'h6, 4'h0, 4'b0000, 1'b0);
        issue(4'b0101, 4'h5, 4'h0, 1'b0); expect_res("not",   4'hA, 4'h0, 4'b0010, 1'b0);
        issue(4'b0110, 4'h7, 4'h0, 1'b0); expect_res("inc_v", 4'h8, 4'h0, 4'b1010, 1'b0);
        issue(4'b0110, 4'hF, 4'h0, 1'b0); expect_res("inc_c", 4'h0, 4'h0, 4'b0101, 1'b0);
        issue(4'b1010, 4'h9, 4'h0, 1'b0); expect_res("shl",   4'h2, 4'h0, 4'b0100, 1'b0);
        issue(4'b1011, 4'h9, 4'h0, 1'b0); expect_res("shr",   4'h4, 4'h0, 4'b0100, 1'b0);

        // Illegal opcode keeps flags; the next legal op clears err.
        issue(4'b1101, 4'h3, 4'h3, 1'b0); expect_res("ill",   4'h0, 4'h0, 4'b0100, 1'b1);
        issue(4'b0100, 4'h3, 4'h3, 1'b0); expect_res("xor_z", 4'h0, 4'h0, 4'b0001, 1'b0);

        // Multiply 15*15; operands are changed after acceptance.
        issue(4'b1100, 4'hF, 4'hF, 1'b0);
        a = 4'h0;
        b = 4'h0;
`ifdef SEQ_ALU_MUL_EN
        for (int k = 0; k < 4; k++) begin
            chk("mul_busy",  32'(busy),      32'd1);
            chk("mul_ready", 32'(in_ready),  32'd0);
            chk("mul_valid", 32'(out_valid), 32'd0);
            tick();
        end
        expect_res("mul", 4'h1, 4'hE, 4'b1110, 1'b0);
        chk("mul_done_busy", 32'(busy), 32'd0);
`else
        expect_res("mul_ill", 4'h0, 4'h0, 4'b0001, 1'b1);
        chk("mul_ill_busy", 32'(busy), 32'd0);
`endif
        tick();

        // Backpressure: result held while the consumer stalls.
        out_ready = 1'b0;
        issue(4'b0000, 4'h3, 4'h4, 1'b0); expect_res("bp_add", 4'h7, 4'h0, 4'b0000, 1'b0);
        op       = 4'b0100;
        a        = 4'hF;
        b        = 4'h0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", 32'(in_ready),  32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_y",     32'(y),         32'd7);
            chk("bp_flags", 32'(flags),     32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        expect_res("bp_next", 4'hF, 4'h0, 4'b0010, 1'b0);
        tick();

        // Asynchronous reset in the middle of a multiply.
        issue(4'b1100, 4'hF, 4'hF, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_flags", 32'(flags),     32'd0);
        chk("arst_y",     32'(y),         32'd0);
        chk("arst_y_hi",  32'(y_hi),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_ready", 32'(in_ready), 32'd1);
        issue(4'b1111, 4'h5, 4'h5, 1'b0); expect_res("arst_ill", 4'h0, 4'h0, 4'b0000, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        chk("arst_no_late_valid", 32'(out_valid), 32'd0);
        chk("arst_no_late_y",     32'(y),         32'd0);
        chk("arst_no_late_busy",  32'(busy),      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
